cellram_port_arbiter: RTL and testbench

//  Shares the single external Cellular RAM (async PSRAM, 16-bit bus) between the CPU instruction-fetch port (IF) and the

---
 rtl/cellram_port_arbiter_pkg.sv | 25 ++
 rtl/cellram_port_arbiter_timer.sv | 34 +++
 rtl/cellram_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 tb/tb_cellram_port_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cellram_port_arbiter_pkg.sv
// Shared types for the Cellular RAM port arbiter.
//   cr_state_e : sequencer states (one 32-bit access = two timed 16-bit bus cycles)
//   cr_port_e  : requester identity (instruction fetch or data memory)
//   max_u      : elaboration-time helper for sizing the phase timer
package cellram_port_arbiter_pkg;

    typedef enum logic [2:0] {
        CrIdle  = 3'd0,
        CrAcc0  = 3'd1,
        CrGap   = 3'd2,
        CrAcc1  = 3'd3,
        CrDone  = 3'd4,
        CrRecov = 3'd5
    } cr_state_e;

    typedef enum logic {
        CrIf = 1'b0,
        CrDm = 1'b1
    } cr_port_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cellram_port_arbiter_timer.sv
// Phase timer for the Cellular RAM sequencer.
// Load a start value, then it counts down to zero and stays there.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   load_i         : load load_val_i this cycle (has priority over counting)
//   load_val_i     : start value (phase length minus one)
//   zero_o         : count is zero, i.e. this is the last cycle of the phase
//   one_o          : count is one, i.e. the next cycle is the last of the phase
module cellram_port_arbiter_timer #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o,
    output logic             one_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign zero_o = (cnt_q == '0);
    assign one_o  = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/cellram_port_arbiter.sv
// Shares the external async Cellular RAM (16-bit bus) between the instruction-fetch port (IF)
// and the load/store port (DM). Each 32-bit access runs as two timed 16-bit bus cycles, low
// half first. All pad-facing strobes, address and data are registered.
//   clk_i, rst_n_i                 : clock, asynchronous active-low reset
//   if_req/addr, if_ack/rdata      : IF read port (level request held until ack)
//   dm_req/we/be/addr/wdata        : DM port request (level, held until ack)
//   dm_ack/rdata                   : DM completion pulse and read word
//   mem_adr_o, mem_db_o/_i/_oe_o   : halfword address, pad data out/in, pad drive enable
//   mem_oe_n_o .. ram_ub_n_o       : active-low bus strobes
//   ram_adv_n_o, ram_clk_o, ram_cre_o : tied low (async mode)
//   busy_o                         : sequencer not idle
module cellram_port_arbiter
    import cellram_port_arbiter_pkg::*;
#(
    parameter int unsigned ACCESS_CYC  = 4,
    parameter int unsigned RECOVER_CYC = 1,
    parameter int unsigned ADDR_W      = 23
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    output logic              if_ack_o,
    output logic [31:0]       if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [3:0]        dm_be_i,
    input  logic [31:0]       dm_addr_i,
    input  logic [31:0]       dm_wdata_i,
    output logic              dm_ack_o,
    output logic [31:0]       dm_rdata_o,
    output logic [ADDR_W-1:0] mem_adr_o,
    output logic [15:0]       mem_db_o,
    input  logic [15:0]       mem_db_i,
    output logic              mem_db_oe_o,
    output logic              mem_oe_n_o,
    output logic              mem_we_n_o,
    output logic              ram_cs_n_o,
    output logic              ram_lb_n_o,
    output logic              ram_ub_n_o,
    output logic              ram_adv_n_o,
    output logic              ram_clk_o,
    output logic              ram_cre_o,
    output logic              busy_o
);

    localparam int unsigned TimerW = $clog2(max_u(ACCESS_CYC, RECOVER_CYC)) + 1;
    localparam logic [TimerW-1:0] AccLoad = TimerW'(ACCESS_CYC - 1);
    localparam logic [TimerW-1:0] RecLoad = TimerW'(RECOVER_CYC - 1);

    cr_state_e          state_q, state_d;
    cr_port_e           gnt_q, gnt_d, last_q, last_d, pick;
    logic [ADDR_W-2:0]  waddr_q, waddr_d, pick_waddr;
    logic               we_q, we_d, pick_we;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [15:0]        lo_q, lo_d;
    logic [ADDR_W-1:0]  adr_q, adr_d;
    logic [15:0]        db_q, db_d;
    logic               db_oe_q, db_oe_d;
    logic               cs_n_q, cs_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic               lb_n_q, lb_n_d, ub_n_q, ub_n_d;
    logic               if_ack_q, if_ack_d, dm_ack_q, dm_ack_d;
    logic [31:0]        if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic               tmr_load, tmr_zero, tmr_one;
    logic [TimerW-1:0]  tmr_val;
    logic               unused_addr;

    cellram_port_arbiter_timer #(
        .WIDTH (TimerW)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero),
        .one_o      (tmr_one)
    );

    // Tie goes to the port that did not win last time; last_q resets to IF so DM wins first.
    assign pick = (if_req_i && dm_req_i) ? ((last_q == CrIf) ? CrDm : CrIf)
                                         : (dm_req_i ? CrDm : CrIf);
    assign pick_we    = (pick == CrDm) && dm_we_i;
    assign pick_waddr = (pick == CrDm) ? dm_addr_i[ADDR_W:2] : if_addr_i[ADDR_W:2];

    assign unused_addr = ^{if_addr_i[31:ADDR_W+1], if_addr_i[1:0],
                           dm_addr_i[31:ADDR_W+1], dm_addr_i[1:0]};

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        waddr_d    = waddr_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        lo_d       = lo_q;
        adr_d      = adr_q;
        db_d       = db_q;
        db_oe_d    = db_oe_q;
        cs_n_d     = cs_n_q;
        oe_n_d     = oe_n_q;
        we_n_d     = we_n_q;
        lb_n_d     = lb_n_q;
        ub_n_d     = ub_n_q;
        if_ack_d   = 1'b0;
        dm_ack_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        tmr_load   = 1'b0;
        tmr_val    = AccLoad;

        unique case (state_q)
            CrIdle: begin
                if (if_req_i || dm_req_i) begin
                    gnt_d    = pick;
                    last_d   = pick;
                    waddr_d  = pick_waddr;
                    we_d     = pick_we;
                    be_d     = dm_be_i;
                    wdata_d  = dm_wdata_i;
                    state_d  = CrAcc0;
                    tmr_load = 1'b1;
                    tmr_val  = AccLoad;
                    // Low half strobes are set up from the unregistered grant values.
                    adr_d    = {pick_waddr, 1'b0};
                    db_d     = dm_wdata_i[15:0];
                    cs_n_d   = 1'b0;
                    oe_n_d   = pick_we;
                    we_n_d   = ~pick_we;
                    db_oe_d  = pick_we;
                    lb_n_d   = pick_we & ~dm_be_i[0];
                    ub_n_d   = pick_we & ~dm_be_i[1];
                end
            end
            CrAcc0: begin
                if (tmr_zero) begin
                    state_d  = CrGap;
                    tmr_load = 1'b1;
                    tmr_val  = RecLoad;
                    if (!we_q) begin
                        lo_d = mem_db_i;
                    end
                    cs_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    db_oe_d = 1'b0;
                    lb_n_d  = 1'b1;
                    ub_n_d  = 1'b1;
                end else if (we_q && tmr_one) begin
                    // Release WE one cycle early so data/address hold past the write edge.
                    we_n_d = 1'b1;
                end
            end
            CrGap: begin
                if (tmr_zero) begin
                    state_d  = CrAcc1;
                    tmr_load = 1'b1;
                    tmr_val  = AccLoad;
                    adr_d    = {waddr_q, 1'b1};
                    db_d     = wdata_q[31:16];
                    cs_n_d   = 1'b0;
                    oe_n_d   = we_q;
                    we_n_d   = ~we_q;
                    db_oe_d  = we_q;
                    lb_n_d   = we_q & ~be_q[2];
                    ub_n_d   = we_q & ~be_q[3];
                end
            end
            CrAcc1: begin
                if (tmr_zero) begin
                    state_d = CrDone;
                    cs_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    db_oe_d = 1'b0;
                    lb_n_d  = 1'b1;
                    ub_n_d  = 1'b1;
                    // Ack and read data are registered together so both appear in DONE.
                    if (gnt_q == CrIf) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = {mem_db_i, lo_q};
                    end else begin
                        dm_ack_d = 1'b1;
                        if (!we_q) begin
                            dm_rdata_d = {mem_db_i, lo_q};
                        end
                    end
                end else if (we_q && tmr_one) begin
                    we_n_d = 1'b1;
                end
            end
            CrDone: begin
                state_d  = CrRecov;
                tmr_load = 1'b1;
                tmr_val  = RecLoad;
            end
            CrRecov: begin
                if (tmr_zero) begin
                    state_d = CrIdle;
                end
            end
            default: begin
                state_d = CrIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= CrIdle;
            gnt_q      <= CrIf;
            last_q     <= CrIf;
            waddr_q    <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            lo_q       <= '0;
            adr_q      <= '0;
            db_q       <= '0;
            db_oe_q    <= 1'b0;
            cs_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            lb_n_q     <= 1'b1;
            ub_n_q     <= 1'b1;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            waddr_q    <= waddr_d;
            we_q       <= we_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            lo_q       <= lo_d;
            adr_q      <= adr_d;
            db_q       <= db_d;
            db_oe_q    <= db_oe_d;
            cs_n_q     <= cs_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            lb_n_q     <= lb_n_d;
            ub_n_q     <= ub_n_d;
            if_ack_q   <= if_ack_d;
            dm_ack_q   <= dm_ack_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign if_ack_o    = if_ack_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_ack_o    = dm_ack_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign mem_adr_o   = adr_q;
    assign mem_db_o    = db_q;
    assign mem_db_oe_o = db_oe_q;
    assign mem_oe_n_o  = oe_n_q;
    assign mem_we_n_o  = we_n_q;
    assign ram_cs_n_o  = cs_n_q;
    assign ram_lb_n_o  = lb_n_q;
    assign ram_ub_n_o  = ub_n_q;
    assign ram_adv_n_o = 1'b0;
    assign ram_clk_o   = 1'b0;
    assign ram_cre_o   = 1'b0;
    assign busy_o      = (state_q != CrIdle);

endmodule

// File: tb/tb_cellram_port_arbiter.sv
module tb_cellram_port_arbiter;

    logic        clk, rst_n;
    logic        if_req, if_ack;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_ack;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [22:0] mem_adr;
    logic [15:0] mem_db_o, mem_db_i;
    logic        mem_db_oe, mem_oe_n, mem_we_n, ram_cs_n, ram_lb_n, ram_ub_n;
    logic        ram_adv_n, ram_clk, ram_cre, busy;

    int total = 0;
    int bad   = 0;

    // Simple async RAM model: drives read data while selected and output-enabled.
    logic [15:0] mem [0:255];
    assign mem_db_i = (!ram_cs_n && !mem_oe_n) ? mem[mem_adr[7:0]] : 16'h0000;

    cellram_port_arbiter dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_ack_o    (if_ack),
        .if_rdata_o  (if_rdata),
        .dm_req_i    (dm_req),
        .dm_we_i     (dm_we),
        .dm_be_i     (dm_be),
        .dm_addr_i   (dm_addr),
        .dm_wdata_i  (dm_wdata),
        .dm_ack_o    (dm_ack),
        .dm_rdata_o  (dm_rdata),
        .mem_adr_o   (mem_adr),
        .mem_db_o    (mem_db_o),
        .mem_db_i    (mem_db_i),
        .mem_db_oe_o (mem_db_oe),
        .mem_oe_n_o  (mem_oe_n),
        .mem_we_n_o  (mem_we_n),
        .ram_cs_n_o  (ram_cs_n),
        .ram_lb_n_o  (ram_lb_n),
        .ram_ub_n_o  (ram_ub_n),
        .ram_adv_n_o (ram_adv_n),
        .ram_clk_o   (ram_clk),
        .ram_cre_o   (ram_cre),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle traces; index i holds the value during the cycle after the (i+1)-th edge.
    logic        cs_tr [0:47];
    logic        we_tr [0:47];
    logic        oe_tr [0:47];
    logic        lb_tr [0:47];
    logic        ub_tr [0:47];
    logic        dboe_tr [0:47];
    logic        busy_tr [0:47];
    logic        ifack_tr [0:47];
    logic        dmack_tr [0:47];
    logic [22:0] adr_tr [0:47];
    logic [15:0] db_tr [0:47];

    int if_first, if_cnt, dm_first, dm_cnt, both_cnt, cs_windows, we_low0, we_low1;
    int order [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n, input int drop_at, input bit auto_drop);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cs_tr[i] = ram_cs_n;   we_tr[i] = mem_we_n;  oe_tr[i] = mem_oe_n;
            lb_tr[i] = ram_lb_n;   ub_tr[i] = ram_ub_n;  dboe_tr[i] = mem_db_oe;
            busy_tr[i] = busy;     ifack_tr[i] = if_ack; dmack_tr[i] = dm_ack;
            adr_tr[i] = mem_adr;   db_tr[i] = mem_db_o;
            if (i == drop_at) begin
                if_req = 1'b0;
                dm_req = 1'b0;
            end
            if (auto_drop && if_ack) if_req = 1'b0;
            if (auto_drop && dm_ack) dm_req = 1'b0;
        end
    endtask

    task automatic scan(input int n);
        logic prev_cs;
        if_first = -1; if_cnt = 0; dm_first = -1; dm_cnt = 0; both_cnt = 0;
        cs_windows = 0; we_low0 = 0; we_low1 = 0; prev_cs = 1'b1;
        order.delete();
        for (int i = 0; i < n; i++) begin
            if (ifack_tr[i]) begin
                if (if_first < 0) if_first = i;
                if_cnt++;
                order.push_back(0);
            end
            if (dmack_tr[i]) begin
                if (dm_first < 0) dm_first = i;
                dm_cnt++;
                order.push_back(1);
            end
            if (ifack_tr[i] && dmack_tr[i]) both_cnt++;
            if (prev_cs && !cs_tr[i]) cs_windows++;
            prev_cs = cs_tr[i];
            if (i <= 3 && !we_tr[i]) we_low0++;
            if (i >= 5 && i <= 8 && !we_tr[i]) we_low1++;
        end
    endtask

    initial begin
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_be = 0; dm_addr = 0; dm_wdata = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        // Byte 0x100 -> halfwords 0x80/0x81; byte 0x104 -> 0x82/0x83; byte 0x8 -> 0x4/0x5.
        mem[8'h80] = 16'h1234; mem[8'h81] = 16'hABCD;
        mem[8'h82] = 16'h0F0F; mem[8'h83] = 16'h7777;
        mem[8'h04] = 16'h5678; mem[8'h05] = 16'h9ABC;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_cs_n", ram_cs_n, 1);
        check("rst_oe_n", mem_oe_n, 1);
        check("rst_we_n", mem_we_n, 1);
        check("rst_lb_ub", {ram_lb_n, ram_ub_n}, 2'b11);
        check("rst_adv_clk_cre", {ram_adv_n, ram_clk, ram_cre}, 3'b000);
        check("rst_db_oe", mem_db_oe, 0);
        check("rst_acks", {if_ack, dm_ack}, 2'b00);
        check("rst_rdata", {if_rdata, dm_rdata}, 0);
        check("rst_adr", mem_adr, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1; rst_n = 1'b1;

        // IF read of byte 0x100.
        if_addr = 32'h0000_0100; if_req = 1'b1;
        run(14, -1, 1'b1); scan(14);
        check("if_ack_latency", if_first + 1, 10);
        check("if_ack_count", if_cnt, 1);
        check("if_no_dm_ack", dm_cnt, 0);
        check("if_rdata", if_rdata, 32'hABCD1234);
        check("if_adr_half0", adr_tr[0], 23'h80);
        check("if_adr_half1", adr_tr[5], 23'h81);
        check("if_rd_strobes", {cs_tr[0], oe_tr[0], we_tr[0], lb_tr[0], ub_tr[0]}, 5'b00100);
        check("if_busy", busy_tr[0], 1);
        check("if_cs_windows", cs_windows, 2);

        // DM full-word write.
        dm_addr = 32'h0000_0008; dm_wdata = 32'hDEADBEEF; dm_be = 4'b1111; dm_we = 1'b1;
        dm_req = 1'b1;
        run(14, -1, 1'b1); scan(14);
        check("wr_adr_half0", adr_tr[0], 23'h4);
        check("wr_db_half0", db_tr[0], 16'hBEEF);
        check("wr_adr_half1", adr_tr[5], 23'h5);
        check("wr_db_half1", db_tr[5], 16'hDEAD);
        check("wr_we_low_half0", we_low0, 3);
        check("wr_we_hold_half0", we_tr[3], 1);
        check("wr_we_low_half1", we_low1, 3);
        check("wr_drive", {dboe_tr[0], oe_tr[0], lb_tr[0], ub_tr[0]}, 4'b1100);
        check("wr_gap_idle", {cs_tr[4], dboe_tr[4]}, 2'b10);
        check("wr_ack_at", dm_first, 9);
        check("wr_ack_count", dm_cnt, 1);
        check("wr_cs_windows", cs_windows, 2);

        // DM write with only byte 2 enabled.
        dm_addr = 32'h0000_0010; dm_wdata = 32'h11223344; dm_be = 4'b0100;
        dm_req = 1'b1;
        run(14, -1, 1'b1); scan(14);
        check("be_half0_lb_ub", {lb_tr[0], ub_tr[0]}, 2'b11);
        check("be_half1_lb_ub", {lb_tr[5], ub_tr[5]}, 2'b01);
        check("be_half1_db", db_tr[5], 16'h1122);
        check("be_ack_count", dm_cnt, 1);
        check("be_cs_windows", cs_windows, 2);

        // DM read, request withdrawn during the gap.
        dm_addr = 32'h0000_0008; dm_we = 1'b0; dm_req = 1'b1;
        run(14, 4, 1'b0); scan(14);
        check("drop_gap_state", {cs_tr[4], busy_tr[4]}, 2'b11);
        check("drop_ack_at", dm_first, 9);
        check("drop_ack_count", dm_cnt, 1);
        check("drop_cs_windows", cs_windows, 2);
        check("drop_rdata", dm_rdata, 32'h9ABC5678);

        // Reset asserted in the second half of a write.
        dm_addr = 32'h0000_0008; dm_wdata = 32'hCAFEF00D; dm_be = 4'b1111; dm_we = 1'b1;
        dm_req = 1'b1;
        run(6, -1, 1'b0);
        check("rst_mid_in_acc1", {ram_cs_n, mem_we_n, adr_tr[5]}, {2'b00, 23'h5});
        #2 rst_n = 1'b0; dm_req = 1'b0;
        #1;
        check("rst_mid_strobes", {ram_cs_n, mem_we_n, mem_oe_n, mem_db_oe}, 4'b1110);
        check("rst_mid_busy_ack", {busy, dm_ack}, 2'b00);
        @(posedge clk); #1; rst_n = 1'b1;
        run(12, -1, 1'b0); scan(12);
        check("rst_mid_no_ack", dm_cnt + if_cnt, 0);
        check("rst_mid_bus_quiet", cs_windows, 0);
        if_addr = 32'h0000_0100; if_req = 1'b1;
        run(14, -1, 1'b1); scan(14);
        check("restart_ack_latency", if_first + 1, 10);
        check("restart_rdata", if_rdata, 32'hABCD1234);

        // Simultaneous requests held high after a fresh reset.
        rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        if_addr = 32'h0000_0104; dm_addr = 32'h0000_0008; dm_we = 1'b0;
        if_req = 1'b1; dm_req = 1'b1;
        run(40, -1, 1'b0); scan(40);
        check("arb_ack_total", order.size(), 3);
        check("arb_first_dm", (order.size() > 0) ? order[0] : -1, 1);
        check("arb_second_if", (order.size() > 1) ? order[1] : -1, 0);
        check("arb_third_dm", (order.size() > 2) ? order[2] : -1, 1);
        check("arb_first_ack_at", dm_first, 9);
        check("arb_if_ack_at", if_first, 21);
        check("arb_never_both", both_cnt, 0);
        check("arb_regrant_gap", {cs_tr[11], cs_tr[12]}, 2'b10);
        check("arb_regrant_adr", adr_tr[12], 23'h82);
        check("arb_if_rdata", if_rdata, 32'h77770F0F);
        check("arb_dm_rdata", dm_rdata, 32'h9ABC5678);
        if_req = 1'b0; dm_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
